// File: rtl/int_pipe_pkg.sv
// Shared types for the two-stage integer pipe: opcode encoding, flag bit
// positions and opcode classification helpers.
package int_pipe_pkg;

  localparam int OP_BITS = 4;

  // Flag register layout: bits [3:0] = {V,C,N,Z}
  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_C = 2;
  localparam int FLG_V = 3;

  typedef enum logic [OP_BITS-1:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_ADC = 4'd8,
    OP_MOV = 4'd9,
    OP_CMP = 4'd10
  } op_e;

  // True for opcodes that produce a register writeback (CMP/NOP/undefined do not)
  function automatic logic op_writes_reg(input op_e op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SHL, OP_SHR, OP_ADC, OP_MOV: op_writes_reg = 1'b1;
      default:                        op_writes_reg = 1'b0;
    endcase
  endfunction

  // True for opcodes that update the flag register (everything but NOP/undefined)
  function automatic logic op_writes_flg(input op_e op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SHL, OP_SHR, OP_ADC, OP_MOV, OP_CMP: op_writes_flg = 1'b1;
      default:                                op_writes_flg = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/int_alu.sv
// Combinational ALU for the execute stage: result, next flags and
// writeback/flag-write qualifiers for the opcode in E.
module int_alu import int_pipe_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int FLG_W = 8,
  parameter int OP_W  = 4
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [FLG_W-1:0] flg_in,
  output logic [WIDTH-1:0] y,
  output logic [FLG_W-1:0] flg_next,
  output logic             wr_reg,
  output logic             wr_flg
);

  localparam int SH_W = $clog2(WIDTH);
  localparam int MSB  = WIDTH - 1;

  op_e             opc_s;
  logic [SH_W-1:0] sh_s;
  logic            cin_s;
  logic [WIDTH:0]  sum_s;
  logic [WIDTH:0]  diff_s;
  logic [WIDTH:0]  shl_s;
  logic [WIDTH:0]  shr_s;
  logic [WIDTH-1:0] y_s;
  logic            c_s;
  logic            v_s;
  logic            unusedFlg_s;

  assign opc_s       = op_e'(op[OP_BITS-1:0]);
  assign unusedFlg_s = ^flg_in;

  // Arithmetic/logic result and carry/overflow per opcode
  always_comb begin
    sh_s   = b[SH_W-1:0];
    cin_s  = (opc_s == OP_ADC) ? flg_in[FLG_C] : 1'b0;
    sum_s  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin_s};
    diff_s = {1'b0, a} - {1'b0, b};
    shl_s  = {1'b0, a} << sh_s;   // top bit = last bit shifted out
    shr_s  = {a, 1'b0} >> sh_s;   // bottom bit = last bit shifted out
    y_s    = '0;
    c_s    = 1'b0;
    v_s    = 1'b0;
    case (opc_s)
      OP_ADD, OP_ADC: begin
        y_s = sum_s[WIDTH-1:0];
        c_s = sum_s[WIDTH];
        v_s = (a[MSB] == b[MSB]) && (sum_s[MSB] != a[MSB]);
      end
      OP_SUB, OP_CMP: begin
        y_s = diff_s[WIDTH-1:0];
        c_s = ~diff_s[WIDTH];     // carry = NOT borrow
        v_s = (a[MSB] != b[MSB]) && (diff_s[MSB] != a[MSB]);
      end
      OP_AND: y_s = a & b;
      OP_OR:  y_s = a | b;
      OP_XOR: y_s = a ^ b;
      OP_MOV: y_s = a;
      OP_SHL: begin
        y_s = shl_s[WIDTH-1:0];
        c_s = shl_s[WIDTH];
      end
      OP_SHR: begin
        y_s = shr_s[WIDTH:1];
        c_s = shr_s[0];
      end
      default: y_s = '0;
    endcase
  end

  // Pack flags and qualifiers
  always_comb begin
    flg_next        = '0;
    flg_next[FLG_Z] = (y_s == '0);
    flg_next[FLG_N] = y_s[MSB];
    flg_next[FLG_C] = c_s;
    flg_next[FLG_V] = v_s;
    y               = y_s;
    wr_reg          = op_writes_reg(opc_s);
    wr_flg          = op_writes_flg(opc_s);
  end

endmodule

// File: rtl/int_pipe_fwd.sv
// Two-stage (execute, writeback) integer pipe with valid bits, RAW handling
// and global hold. Optional macro INTPIPE_BYPASS_EN selects operand
// forwarding; without it, RAW hazards stall issue until writeback completes.
module int_pipe_fwd import int_pipe_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 3,
  parameter int OP_W  = 4,
  parameter int FLG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [SEL_W-1:0] a_sel,
  input  logic [SEL_W-1:0] b_sel,
  input  logic [SEL_W-1:0] c_sel,
  output logic [SEL_W-1:0] rf_a_sel,
  output logic [SEL_W-1:0] rf_b_sel,
  input  logic [WIDTH-1:0] rf_a_dat,
  input  logic [WIDTH-1:0] rf_b_dat,
  output logic             wb_en,
  output logic [SEL_W-1:0] wb_sel,
  output logic [WIDTH-1:0] wb_dat,
  output logic [FLG_W-1:0] flg_out
);

  // E stage
  logic             eValid_r;
  logic [OP_W-1:0]  eOp_r;
  logic [WIDTH-1:0] eA_r;
  logic [WIDTH-1:0] eB_r;
  logic [SEL_W-1:0] eSel_r;
  // W stage (wWrite_r = valid op that writes a register)
  logic             wWrite_r;
  logic [SEL_W-1:0] wbSel_r;
  logic [WIDTH-1:0] wbDat_r;
  logic [FLG_W-1:0] flg_r;

  logic [WIDTH-1:0] aluY_s;
  logic [FLG_W-1:0] aluFlg_s;
  logic             aluWrReg_s;
  logic             aluWrFlg_s;
  logic             eLive_s;
  logic             aHitE_s, aHitW_s, bHitE_s, bHitW_s;
  logic             stall_s;
  logic             inReady_s;
  logic             accept_s;
  logic [WIDTH-1:0] opA_s;
  logic [WIDTH-1:0] opB_s;

  int_alu #(.WIDTH(WIDTH), .FLG_W(FLG_W), .OP_W(OP_W)) uAlu (
    .op       (eOp_r),
    .a        (eA_r),
    .b        (eB_r),
    .flg_in   (flg_r),
    .y        (aluY_s),
    .flg_next (aluFlg_s),
    .wr_reg   (aluWrReg_s),
    .wr_flg   (aluWrFlg_s)
  );

  assign rf_a_sel = a_sel;
  assign rf_b_sel = b_sel;
  assign in_ready = inReady_s;
  assign wb_en    = wWrite_r & ~hold & ~rst;
  assign wb_sel   = wbSel_r;
  assign wb_dat   = wbDat_r;
  assign flg_out  = flg_r;

  // Hazard detection against in-flight writers, operand selection, issue handshake
  always_comb begin
    eLive_s = eValid_r & aluWrReg_s;
    aHitE_s = eLive_s  & (eSel_r  == a_sel);
    bHitE_s = eLive_s  & (eSel_r  == b_sel);
    aHitW_s = wWrite_r & (wbSel_r == a_sel);
    bHitW_s = wWrite_r & (wbSel_r == b_sel);
`ifdef INTPIPE_BYPASS_EN
    stall_s = 1'b0;
    // Newest producer wins: E result over W result over register file
    if (aHitE_s) begin
      opA_s = aluY_s;
    end else if (aHitW_s) begin
      opA_s = wbDat_r;
    end else begin
      opA_s = rf_a_dat;
    end
    if (bHitE_s) begin
      opB_s = aluY_s;
    end else if (bHitW_s) begin
      opB_s = wbDat_r;
    end else begin
      opB_s = rf_b_dat;
    end
`else
    stall_s = aHitE_s | aHitW_s | bHitE_s | bHitW_s;
    opA_s   = rf_a_dat;
    opB_s   = rf_b_dat;
`endif
    inReady_s = ~rst & ~hold & ~stall_s;
    accept_s  = in_valid & inReady_s;
  end

  // Pipeline state: advance E->W and issue->E unless held; reset flushes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      eValid_r <= 1'b0;
      eOp_r    <= '0;
      eA_r     <= '0;
      eB_r     <= '0;
      eSel_r   <= '0;
      wWrite_r <= 1'b0;
      wbSel_r  <= '0;
      wbDat_r  <= '0;
      flg_r    <= '0;
    end else if (!hold) begin
      eValid_r <= accept_s;
      if (accept_s) begin
        eOp_r  <= op;
        eA_r   <= opA_s;
        eB_r   <= opB_s;
        eSel_r <= c_sel;
      end
      wWrite_r <= eLive_s;
      if (eLive_s) begin
        wbSel_r <= eSel_r;
        wbDat_r <= aluY_s;
      end
      if (eValid_r && aluWrFlg_s) begin
        flg_r <= aluFlg_s;
      end
    end
  end

endmodule
